// File: rtl/turbo_pkg.sv
// Shared turbo code definitions: FSM states, constituent trellis and
// interleaver index, common to the encoder and the max-log-MAP decoder.
package turbo_pkg;

    localparam int DEF_INPUT_SIZE  = 5;
    localparam int DEF_EXTEND_SIZE = DEF_INPUT_SIZE + 2;

    typedef enum logic {
        COLLECT = 1'b0,
        ENCODE  = 1'b1
    } enc_state_e;

    // State {s1,s0} = {u(k-1), u(k-2)}; shift the new bit in.
    function automatic logic [1:0] rsc_next(
        input logic [1:0] s,
        input logic       u
    );
        return {u, s[1]};
    endfunction

    // Parity is u XOR u(k-2).
    function automatic logic rsc_parity(
        input logic [1:0] s,
        input logic       u
    );
        return u ^ s[0];
    endfunction

    // Interleaver read index pi(i) = (mul*i + add) mod n.
    function automatic int intlv_index(
        input int i,
        input int n,
        input int mul,
        input int add
    );
        return (mul * i + add) % n;
    endfunction

endpackage

// File: rtl/turbo_encoder_rsc_step.sv
// One combinational step of the 4-state constituent encoder.
// Used twice: natural-order and interleaved-order parity.
module rsc_step
    import turbo_pkg::*;
(
    input  logic [1:0] state_i,
    input  logic       u_i,
    output logic [1:0] next_state_o,
    output logic       parity_o
);

    // Single trellis branch from (state, u).
    always_comb begin
        next_state_o = rsc_next(state_i, u_i);
        parity_o     = rsc_parity(state_i, u_i);
    end

endmodule

// File: rtl/turbo_encoder.sv
// Block turbo encoder: collects INPUT_SIZE bits, then streams
// INPUT_SIZE+2 terminated antipodal symbols (sys, par1, par2).
module turbo_encoder
    import turbo_pkg::*;
#(
    parameter int INPUT_SIZE  = DEF_INPUT_SIZE,
    parameter int EXTEND_SIZE = INPUT_SIZE + 2,
    parameter int OUT_WIDTH   = 7,
    parameter int AMP         = 16,
    parameter int INTLV_MUL   = 3,
    parameter int INTLV_ADD   = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        in_valid_i,
    input  logic                        in_bit_i,
    output logic                        in_ready_o,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic signed [OUT_WIDTH-1:0] sys_o,
    output logic signed [OUT_WIDTH-1:0] par1_o,
    output logic signed [OUT_WIDTH-1:0] par2_o,
    output logic                        last_o
);

    localparam int CW = $clog2(EXTEND_SIZE);
    localparam logic [CW-1:0] LAST_IN  = CW'(INPUT_SIZE - 1);
    localparam logic [CW-1:0] LAST_SYM = CW'(EXTEND_SIZE - 1);
    localparam logic signed [OUT_WIDTH-1:0] POS_V = OUT_WIDTH'(AMP);
    localparam logic signed [OUT_WIDTH-1:0] NEG_V = -POS_V;

    enc_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [INPUT_SIZE-1:0] buf_q, buf_d;
    logic [1:0] st1_q, st1_d;
    logic [1:0] st2_q, st2_d;
    logic [1:0] nx1_q, nx1_d;
    logic [1:0] nx2_q, nx2_d;
    logic u_d, v_d;
    logic p1_d, p2_d;
    logic valid_q, valid_d;
    logic last_q, last_d;
    logic signed [OUT_WIDTH-1:0] sys_q, sys_d;
    logic signed [OUT_WIDTH-1:0] par1_q, par1_d;
    logic signed [OUT_WIDTH-1:0] par2_q, par2_d;

    // FSM next state, bit buffer writes, counter and encoder advance.
    // nx*_q holds the state after the presented symbol, so an output
    // transfer simply adopts it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        st1_d   = st1_q;
        st2_d   = st2_q;
        unique case (state_q)
            COLLECT: begin
                if (in_valid_i) begin
                    for (int j = 0; j < INPUT_SIZE; j++) begin
                        if (int'(cnt_q) == j) begin
                            buf_d[j] = in_bit_i;
                        end
                    end
                    if (cnt_q == LAST_IN) begin
                        cnt_d   = '0;
                        state_d = ENCODE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ENCODE: begin
                if (out_ready_i) begin
                    if (cnt_q == LAST_SYM) begin
                        cnt_d   = '0;
                        st1_d   = 2'b00;
                        st2_d   = 2'b00;
                        state_d = COLLECT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        st1_d = nx1_q;
                        st2_d = nx2_q;
                    end
                end
            end
        endcase
    end

    // Select natural and interleaved input bits for the next symbol;
    // tail steps feed zeros to terminate both encoders.
    always_comb begin
        u_d = 1'b0;
        v_d = 1'b0;
        if (int'(cnt_d) < INPUT_SIZE) begin
            for (int j = 0; j < INPUT_SIZE; j++) begin
                if (int'(cnt_d) == j) begin
                    u_d = buf_d[j];
                end
                if (intlv_index(int'(cnt_d), INPUT_SIZE,
                                INTLV_MUL, INTLV_ADD) == j) begin
                    v_d = buf_d[j];
                end
            end
        end
    end

    rsc_step u_rsc_nat (
        .state_i      (st1_d),
        .u_i          (u_d),
        .next_state_o (nx1_d),
        .parity_o     (p1_d)
    );

    rsc_step u_rsc_int (
        .state_i      (st2_d),
        .u_i          (v_d),
        .next_state_o (nx2_d),
        .parity_o     (p2_d)
    );

    // Map the next symbol's bits to antipodal values; zero when idle.
    always_comb begin
        valid_d = (state_d == ENCODE);
        last_d  = 1'b0;
        sys_d   = '0;
        par1_d  = '0;
        par2_d  = '0;
        if (valid_d) begin
            last_d = (cnt_d == LAST_SYM);
            sys_d  = u_d  ? POS_V : NEG_V;
            par1_d = p1_d ? POS_V : NEG_V;
            par2_d = p2_d ? POS_V : NEG_V;
        end
    end

    // State, buffer, encoder and registered symbol outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            buf_q   <= '0;
            st1_q   <= 2'b00;
            st2_q   <= 2'b00;
            nx1_q   <= 2'b00;
            nx2_q   <= 2'b00;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            sys_q   <= '0;
            par1_q  <= '0;
            par2_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            st1_q   <= st1_d;
            st2_q   <= st2_d;
            nx1_q   <= nx1_d;
            nx2_q   <= nx2_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            sys_q   <= sys_d;
            par1_q  <= par1_d;
            par2_q  <= par2_d;
        end
    end

    assign in_ready_o  = (state_q == COLLECT);
    assign out_valid_o = valid_q;
    assign last_o      = last_q;
    assign sys_o       = sys_q;
    assign par1_o      = par1_q;
    assign par2_o      = par2_q;

endmodule

// File: tb/tb_turbo_encoder.sv
// Scoreboard bench for turbo_encoder: expected symbols are queued
// when a block is driven and popped as the encoder emits them.
module tb_turbo_encoder;

    typedef struct {
        logic signed [6:0] s;
        logic signed [6:0] p1;
        logic signed [6:0] p2;
        logic              last;
    } sym_t;

    localparam logic signed [6:0] PV = 7'sd16;
    localparam logic signed [6:0] NV = -7'sd16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_bit = 1'b0;
    logic in_ready;
    logic out_valid;
    logic out_ready = 1'b1;
    logic signed [6:0] sys;
    logic signed [6:0] par1;
    logic signed [6:0] par2;
    logic last;

    sym_t exp_q[$];
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    turbo_encoder dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .in_valid_i  (in_valid),
        .in_bit_i    (in_bit),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .sys_o       (sys),
        .par1_o      (par1),
        .par2_o      (par2),
        .last_o      (last)
    );

    // Expected symbols for block 1,0,1,1,0 written out by hand.
    task automatic push_table1();
        int ts[7] = '{16, -16, 16, 16, -16, -16, -16};
        int t1[7] = '{16, -16, -16, 16, 16, 16, -16};
        int t2[7] = '{-16, -16, 16, 16, -16, 16, 16};
        sym_t e;
        for (int k = 0; k < 7; k++) begin
            e.s = 7'(ts[k]);
            e.p1 = 7'(t1[k]);
            e.p2 = 7'(t2[k]);
            e.last = (k == 6);
            exp_q.push_back(e);
        end
    endtask

    // Reference model: b[k] is information bit k.
    task automatic push_model(input logic [4:0] b);
        logic [1:0] s1;
        logic [1:0] s2;
        logic u, v, q1, q2;
        sym_t e;
        s1 = 2'b00;
        s2 = 2'b00;
        for (int k = 0; k < 7; k++) begin
            u = (k < 5) ? b[k] : 1'b0;
            v = (k < 5) ? b[(3 * k + 1) % 5] : 1'b0;
            q1 = u ^ s1[0];
            q2 = v ^ s2[0];
            s1 = {u, s1[1]};
            s2 = {v, s2[1]};
            e.s = u ? PV : NV;
            e.p1 = q1 ? PV : NV;
            e.p2 = q2 ? PV : NV;
            e.last = (k == 6);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_bits(input logic [4:0] b, input int nbits);
        int i = 0;
        int cyc = 0;
        while (i < nbits && cyc < 50) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_bit = b[i];
            if (in_ready) i++;
            cyc++;
        end
        n_checks++;
        if (i != nbits) begin
            n_fail++;
            $display("FAIL send_timeout sent %0d required %0d", i, nbits);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1;
        in_bit = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({in_ready, out_valid, last} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_flags actual %b required 100",
                     {in_ready, out_valid, last});
        end
        n_checks++;
        if ({sys, par1, par2} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_data actual %0d/%0d/%0d required 0/0/0",
                     sys, par1, par2);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int cyc = 0;
        sym_t e;
        push_table1();
        send_bits(5'b01101, 5);
        while (exp_q.size() > 0 && cyc < 20) begin
            @(negedge clk);
            in_valid = 1'b0;
            out_ready = 1'b1;
            if (cyc == 0) begin
                n_checks++;
                if ({out_valid, in_ready} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL basic_latency actual %b required 10",
                             {out_valid, in_ready});
                end
            end
            if (out_valid) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({sys, par1, par2, last} !== {e.s, e.p1, e.p2, e.last}) begin
                    n_fail++;
                    $display("FAIL basic_sym actual %0d/%0d/%0d/%b required %0d/%0d/%0d/%b",
                             sys, par1, par2, last, e.s, e.p1, e.p2, e.last);
                end
            end
            cyc++;
        end
        n_checks++;
        if (cyc != 7 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL basic_cycles actual %0d required 7", cyc);
        end
        @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL basic_return actual %b required 10",
                     {in_ready, out_valid});
        end
        exp_q.delete();
    endtask

    task automatic test_all_zero();
        int cyc = 0;
        sym_t e;
        push_model(5'b00000);
        send_bits(5'b00000, 5);
        while (exp_q.size() > 0 && cyc < 20) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({sys, par1, par2, last} !== {NV, NV, NV, e.last}) begin
                    n_fail++;
                    $display("FAIL zero_sym actual %0d/%0d/%0d/%b required -16/-16/-16/%b",
                             sys, par1, par2, last, e.last);
                end
            end
            cyc++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL zero_timeout actual %0d left required 0", exp_q.size());
        end
        @(negedge clk);
        n_checks++;
        if ({dut.st1_q, dut.st2_q} !== 4'b0000) begin
            n_fail++;
            $display("FAIL zero_enc_state actual %b required 0000",
                     {dut.st1_q, dut.st2_q});
        end
        exp_q.delete();
    endtask

    task automatic test_stall();
        int cyc = 0;
        bit prev_stall = 0;
        logic [21:0] held = '0;
        sym_t e;
        push_table1();
        send_bits(5'b01101, 5);
        while (exp_q.size() > 0 && cyc < 40) begin
            @(negedge clk);
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            in_valid = 1'b1;
            in_bit = cyc[0];
            if (prev_stall) begin
                n_checks++;
                if ({sys, par1, par2, last} !== held) begin
                    n_fail++;
                    $display("FAIL stall_hold actual %h required %h",
                             {sys, par1, par2, last}, held);
                end
            end
            if (out_valid) begin
                n_checks++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_ready actual %b required 0", in_ready);
                end
            end
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({sys, par1, par2, last} !== {e.s, e.p1, e.p2, e.last}) begin
                    n_fail++;
                    $display("FAIL stall_sym actual %0d/%0d/%0d/%b required %0d/%0d/%0d/%b",
                             sys, par1, par2, last, e.s, e.p1, e.p2, e.last);
                end
            end
            prev_stall = out_valid && !out_ready;
            held = {sys, par1, par2, last};
            cyc++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL stall_timeout actual %0d left required 0", exp_q.size());
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [9:0] bits = {5'b10110, 5'b01101};
        int i = 0;
        int cyc = 0;
        int first_last = -10;
        int acc2 = -1;
        sym_t e;
        push_model(5'b01101);
        push_model(5'b10110);
        while (exp_q.size() > 0 && cyc < 60) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid = (i < 10);
            in_bit = (i < 10) ? bits[i] : 1'b0;
            if (in_ready && i < 10) begin
                if (i == 5) acc2 = cyc;
                i++;
            end
            if (out_valid) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({sys, par1, par2, last} !== {e.s, e.p1, e.p2, e.last}) begin
                    n_fail++;
                    $display("FAIL b2b_sym actual %0d/%0d/%0d/%b required %0d/%0d/%0d/%b",
                             sys, par1, par2, last, e.s, e.p1, e.p2, e.last);
                end
                if (last && first_last < 0) first_last = cyc;
            end
            cyc++;
        end
        n_checks++;
        if (acc2 != first_last + 1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_gap actual accept %0d required %0d",
                     acc2, first_last + 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset_mid_input();
        int cyc = 0;
        sym_t e;
        send_bits(5'b11111, 3);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, out_valid, last, sys, par1, par2} !== {3'b100, 21'd0}) begin
            n_fail++;
            $display("FAIL rst_in_outputs actual %b/%0d/%0d/%0d required 100/0/0/0",
                     {in_ready, out_valid, last}, sys, par1, par2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        push_table1();
        send_bits(5'b01101, 5);
        while (exp_q.size() > 0 && cyc < 20) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({sys, par1, par2, last} !== {e.s, e.p1, e.p2, e.last}) begin
                    n_fail++;
                    $display("FAIL rst_in_sym actual %0d/%0d/%0d/%b required %0d/%0d/%0d/%b",
                             sys, par1, par2, last, e.s, e.p1, e.p2, e.last);
                end
            end
            cyc++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rst_in_timeout actual %0d left required 0", exp_q.size());
        end
        @(negedge clk);
        exp_q.delete();
    endtask

    task automatic test_reset_mid_encode();
        int t = 0;
        int cyc = 0;
        sym_t e;
        push_model(5'b01101);
        send_bits(5'b01101, 5);
        while (t < 3 && cyc < 20) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({sys, par1, par2, last} !== {e.s, e.p1, e.p2, e.last}) begin
                    n_fail++;
                    $display("FAIL rst_enc_pre actual %0d/%0d/%0d/%b required %0d/%0d/%0d/%b",
                             sys, par1, par2, last, e.s, e.p1, e.p2, e.last);
                end
                t++;
            end
            cyc++;
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_enc_valid_before actual %b required 1", out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL rst_enc_async actual %b required 01", {out_valid, in_ready});
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        push_model(5'b10110);
        send_bits(5'b10110, 5);
        while (exp_q.size() > 0 && cyc < 20) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({sys, par1, par2, last} !== {e.s, e.p1, e.p2, e.last}) begin
                    n_fail++;
                    $display("FAIL rst_enc_post actual %0d/%0d/%0d/%b required %0d/%0d/%0d/%b",
                             sys, par1, par2, last, e.s, e.p1, e.p2, e.last);
                end
            end
            cyc++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rst_enc_timeout actual %0d left required 0", exp_q.size());
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_zero();
        test_stall();
        test_back_to_back();
        test_reset_mid_input();
        test_reset_mid_encode();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
